// File: rtl/power_multi_switch.sv
// Power-domain switch controller: sequences NUM_STAGES switch segments on/off with settle delays.
// Optional ack-timeout supervision is enabled by defining POWER_SWITCH_TIMEOUT_EN.
module power_multi_switch #(
    parameter int NUM_STAGES     = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int CNT_W          = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  async_reset,
    output logic                  parent_request,
    input  logic                  parent_ready,
    input  logic                  parent_silent,
    input  logic                  parent_starting,
    input  logic                  parent_stopping,
    input  logic                  child_request,
    output logic                  child_ready,
    output logic                  child_silent,
    output logic                  child_starting,
    output logic                  child_stopping,
    output logic [NUM_STAGES-1:0] switch_enb,
    input  logic [NUM_STAGES-1:0] switch_ack,
    output logic                  switch_fault
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {
        ST_SILENT      = 3'd0,
        ST_WAIT_PARENT = 3'd1,
        ST_ON_STAGE    = 3'd2,
        ST_ON_SETTLE   = 3'd3,
        ST_READY       = 3'd4,
        ST_OFF_STAGE   = 3'd5,
        ST_OFF_SETTLE  = 3'd6,
        ST_RELEASE     = 3'd7
    } state_t;

    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [NUM_STAGES-1:0] enb_r;
    logic [4:0]            status_r;  // {parent_request, ready, silent, starting, stopping}

    logic                  abort_s;
    state_t                abort_state_s;
    logic [IDX_W-1:0]      abort_idx_s;
    logic [IDX_W-1:0]      idx_inc_s;
    logic [IDX_W-1:0]      idx_dec_s;
    logic                  settle_done_s;
    logic                  timeout_s;
    logic                  fault_s;
    logic                  unused_parent_status_s;

    function automatic logic [4:0] status_of(input state_t s);
        case (s)
            ST_SILENT:                                status_of = 5'b0_0100;
            ST_WAIT_PARENT, ST_ON_STAGE, ST_ON_SETTLE: status_of = 5'b1_0010;
            ST_READY:                                 status_of = 5'b1_1000;
            ST_OFF_STAGE, ST_OFF_SETTLE:              status_of = 5'b1_0001;
            ST_RELEASE:                               status_of = 5'b0_0001;
            default:                                  status_of = 5'b0_0100;
        endcase
    endfunction

    assign unused_parent_status_s = parent_starting ^ parent_stopping;

    // Abort target: unwind from the highest segment that is actually enabled.
    always_comb begin
        abort_s       = !child_request || !parent_ready;
        idx_inc_s     = idx_r + IDX_W'(1);
        idx_dec_s     = idx_r - IDX_W'(1);
        settle_done_s = (cnt_r <= CNT_W'(1));
        if (enb_r[idx_r]) begin
            abort_state_s = ST_OFF_STAGE;
            abort_idx_s   = idx_r;
        end else if (idx_r != IDX_W'(0)) begin
            abort_state_s = ST_OFF_STAGE;
            abort_idx_s   = idx_dec_s;
        end else begin
            abort_state_s = ST_RELEASE;
            abort_idx_s   = idx_r;
        end
    end

`ifdef POWER_SWITCH_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WAIT_W-1:0] wait_r;
    logic              fault_r;
    logic              wait_full_s;
    logic              stage_hold_s;

    // Timeout fires only while the expected ack level is still missing.
    always_comb begin
        wait_full_s = (wait_r == WAIT_W'(TIMEOUT_CYCLES - 1));
        case (state_r)
            ST_ON_STAGE: begin
                timeout_s    = wait_full_s && !switch_ack[idx_r];
                stage_hold_s = !abort_s && !switch_ack[idx_r] && !timeout_s;
            end
            ST_OFF_STAGE: begin
                timeout_s    = wait_full_s && switch_ack[idx_r];
                stage_hold_s = switch_ack[idx_r] && !timeout_s;
            end
            default: begin
                timeout_s    = 1'b0;
                stage_hold_s = 1'b0;
            end
        endcase
    end

    // Ack wait counter and sticky fault flag.
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            wait_r  <= '0;
            fault_r <= 1'b0;
        end else begin
            wait_r <= stage_hold_s ? (wait_r + WAIT_W'(1)) : '0;
            if (timeout_s) begin
                fault_r <= 1'b1;
            end
        end
    end

    assign fault_s      = fault_r;
    assign switch_fault = fault_r;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_s    = 1'b0;
    assign fault_s      = 1'b0;
    assign switch_fault = 1'b0;
`endif

    // Sequencing FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state_r  <= ST_SILENT;
            idx_r    <= '0;
            cnt_r    <= '0;
            enb_r    <= '0;
            status_r <= status_of(ST_SILENT);
        end else begin
            case (state_r)
                ST_SILENT: begin
                    if (child_request && !fault_s) begin
                        state_r  <= ST_WAIT_PARENT;
                        status_r <= status_of(ST_WAIT_PARENT);
                    end
                end
                ST_WAIT_PARENT: begin
                    if (!child_request) begin
                        state_r  <= ST_RELEASE;
                        status_r <= status_of(ST_RELEASE);
                    end else if (parent_ready) begin
                        state_r  <= ST_ON_STAGE;
                        status_r <= status_of(ST_ON_STAGE);
                        idx_r    <= '0;
                        enb_r[0] <= 1'b1;
                    end
                end
                ST_ON_STAGE: begin
                    if (abort_s || timeout_s) begin
                        state_r            <= abort_state_s;
                        status_r           <= status_of(abort_state_s);
                        idx_r              <= abort_idx_s;
                        enb_r[abort_idx_s] <= 1'b0;
                    end else if (switch_ack[idx_r]) begin
                        state_r <= ST_ON_SETTLE;
                        cnt_r   <= CNT_W'(SETTLE_CYCLES);
                    end
                end
                ST_ON_SETTLE: begin
                    if (abort_s) begin
                        state_r            <= abort_state_s;
                        status_r           <= status_of(abort_state_s);
                        idx_r              <= abort_idx_s;
                        enb_r[abort_idx_s] <= 1'b0;
                    end else if (settle_done_s) begin
                        if (idx_r == IDX_W'(NUM_STAGES - 1)) begin
                            state_r  <= ST_READY;
                            status_r <= status_of(ST_READY);
                        end else begin
                            state_r          <= ST_ON_STAGE;
                            idx_r            <= idx_inc_s;
                            enb_r[idx_inc_s] <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (abort_s) begin
                        state_r      <= ST_OFF_STAGE;
                        status_r     <= status_of(ST_OFF_STAGE);
                        enb_r[idx_r] <= 1'b0;
                    end
                end
                ST_OFF_STAGE: begin
                    if (!switch_ack[idx_r] || timeout_s) begin
                        state_r <= ST_OFF_SETTLE;
                        cnt_r   <= CNT_W'(SETTLE_CYCLES);
                    end
                end
                ST_OFF_SETTLE: begin
                    if (settle_done_s) begin
                        if (idx_r == IDX_W'(0)) begin
                            state_r  <= ST_RELEASE;
                            status_r <= status_of(ST_RELEASE);
                        end else begin
                            state_r          <= ST_OFF_STAGE;
                            idx_r            <= idx_dec_s;
                            enb_r[idx_dec_s] <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (parent_silent) begin
                        state_r  <= ST_SILENT;
                        status_r <= status_of(ST_SILENT);
                    end
                end
                default: begin
                    state_r  <= ST_SILENT;
                    status_r <= status_of(ST_SILENT);
                    idx_r    <= '0;
                    cnt_r    <= '0;
                    enb_r    <= '0;
                end
            endcase
        end
    end

    assign parent_request = status_r[4];
    assign child_ready    = status_r[3];
    assign child_silent   = status_r[2];
    assign child_starting = status_r[1];
    assign child_stopping = status_r[0];
    assign switch_enb     = enb_r;

endmodule
